// File: rtl/audioport_pkg.sv
// Shared definitions for the audio port blocks.
//   AUDIO_BITS      - bits per channel sample
//   I2S_FRAME_BITS  - bits per stereo I2S frame (left + right)
//   i2s_state_t     - serialiser sequencing states
package audioport_pkg;

    localparam int AUDIO_BITS     = 24;
    localparam int I2S_FRAME_BITS = 2*AUDIO_BITS;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } i2s_state_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit-clock and word-select generator.
// Ports:
//   clk        - mclk-domain clock
//   rst        - synchronous active-high reset
//   en         - 1 while a frame is being serialised; 0 freezes counters at 0
//   sck_out    - registered serial bit clock (low for the first half of a bit period)
//   ws_out     - registered word select, one bit early relative to the channel data
//   shift_stb  - high in the last clk cycle of every bit period
//   frame_end  - high in the last clk cycle of the last bit of a frame
module i2s_clkgen
    import audioport_pkg::*;
#(
    parameter int DATABITS = AUDIO_BITS,
    parameter int SCK_DIV  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck_out,
    output logic ws_out,
    output logic shift_stb,
    output logic frame_end
);

    localparam int FRAME_BITS = 2*DATABITS;
    localparam int CW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BW = $clog2(FRAME_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(SCK_DIV-1);
    localparam logic [CW-1:0] CNT_HALF = CW'(SCK_DIV/2);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS-1);
    localparam logic [BW-1:0] WS_FIRST = BW'(DATABITS-1);
    localparam logic [BW-1:0] WS_LAST  = BW'(FRAME_BITS-2);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [BW-1:0] bitidx;
    logic [BW-1:0] bitidx_nxt;
    logic          wrap;

    assign wrap      = en && (cnt == CNT_LAST);
    assign shift_stb = wrap;
    assign frame_end = wrap && (bitidx == BIT_LAST);

    always_comb begin
        cnt_nxt    = '0;
        bitidx_nxt = '0;
        if (en) begin
            cnt_nxt = wrap ? '0 : cnt + CW'(1);
            if (wrap) begin
                bitidx_nxt = (bitidx == BIT_LAST) ? '0 : bitidx + BW'(1);
            end else begin
                bitidx_nxt = bitidx;
            end
        end
    end

    // sck/ws are derived from the next counter values so that they line up
    // with the counters in the same cycle rather than lagging by one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bitidx  <= '0;
            sck_out <= 1'b0;
            ws_out  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            bitidx  <= bitidx_nxt;
            sck_out <= en && (cnt_nxt >= CNT_HALF);
            ws_out  <= en && (bitidx_nxt >= WS_FIRST) && (bitidx_nxt <= WS_LAST);
        end
    end

endmodule

// File: rtl/i2s_unit.sv
// I2S transmitter: requests sample pairs, buffers them on tick_in and
// serialises left then right channel, MSB first, with one-bit ws offset.
// Ports:
//   clk        - mclk-domain clock
//   rst        - synchronous active-high reset
//   play_in    - level; 1 streams audio, 0 stops at the next frame end
//   tick_in    - one-cycle strobe qualifying audio0_in/audio1_in
//   audio0_in  - left sample (two's complement)
//   audio1_in  - right sample (two's complement)
//   req_out    - one-cycle pulse asking for the next sample pair
//   sck_out    - serial bit clock
//   ws_out     - word select (0 = left, 1 = right)
//   sdo_out    - serial data
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | outputs quiet, counters frozen at 0, waiting for play_in
// RUN      | streaming; a new frame is loaded at every frame end
// STOPPING | finishing the current frame, then IDLE unless play returns
module i2s_unit
    import audioport_pkg::*;
#(
    parameter int DATABITS = AUDIO_BITS,
    parameter int SCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                play_in,
    input  logic                tick_in,
    input  logic [DATABITS-1:0] audio0_in,
    input  logic [DATABITS-1:0] audio1_in,
    output logic                req_out,
    output logic                sck_out,
    output logic                ws_out,
    output logic                sdo_out
);

    localparam int FRAME_BITS = 2*DATABITS;

    i2s_state_t            state;
    logic [FRAME_BITS-1:0] sample_buf;
    logic [FRAME_BITS-1:0] shreg;
    logic                  run_en;
    logic                  shift_stb;
    logic                  frame_end;
    logic                  load;

    assign run_en  = (state != IDLE);
    assign sdo_out = shreg[FRAME_BITS-1];

    i2s_clkgen #(
        .DATABITS (DATABITS),
        .SCK_DIV  (SCK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .en        (run_en),
        .sck_out   (sck_out),
        .ws_out    (ws_out),
        .shift_stb (shift_stb),
        .frame_end (frame_end)
    );

    // A frame is loaded on start-up and at every frame end that continues streaming.
    always_comb begin
        load = 1'b0;
        case (state)
            IDLE:     load = play_in;
            RUN:      load = frame_end;
            STOPPING: load = frame_end && play_in;
            default:  load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sample_buf <= '0;
            shreg      <= '0;
            req_out    <= 1'b0;
        end else begin
            req_out <= load;

            // Tick wins over the load-time clear, so a tick coinciding with a
            // load is kept for the following frame.
            if (tick_in) begin
                sample_buf <= {audio0_in, audio1_in};
            end else if (load) begin
                sample_buf <= '0;
            end

            // After the 48th shift the register is empty, so a stop leaves sdo at 0.
            if (load) begin
                shreg <= sample_buf;
            end else if (shift_stb) begin
                shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            end

            case (state)
                IDLE: begin
                    if (play_in) state <= RUN;
                end
                RUN: begin
                    if (!play_in) state <= STOPPING;
                end
                STOPPING: begin
                    if (play_in) begin
                        state <= RUN;
                    end else if (frame_end) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_unit.sv
module tb_i2s_unit;
    import audioport_pkg::*;

    localparam int DB        = AUDIO_BITS;
    localparam int DIV       = 4;
    localparam int FRAME_CYC = I2S_FRAME_BITS*DIV;

    logic          clk = 1'b0;
    logic          rst;
    logic          play;
    logic          tick;
    logic [DB-1:0] a0;
    logic [DB-1:0] a1;
    logic          req;
    logic          sck;
    logic          ws;
    logic          sdo;

    int            n_checks = 0;
    int            n_err    = 0;
    logic [47:0]   exp_q[$];
    int            restart_cnt = 0;
    int            fc;

    always #5 clk = ~clk;

    i2s_unit #(
        .DATABITS (DB),
        .SCK_DIV  (DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .play_in   (play),
        .tick_in   (tick),
        .audio0_in (a0),
        .audio1_in (a1),
        .req_out   (req),
        .sck_out   (sck),
        .ws_out    (ws),
        .sdo_out   (sdo)
    );

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic to_cyc(input int t);
        while (fc < t) begin
            @(negedge clk);
            fc++;
        end
    endtask

    task automatic wait_req(input string name, input int lim);
        int n = 0;
        do begin
            @(negedge clk);
            fc++;
            n++;
        end while (!req && n < lim);
        check(name, 48'(req), 48'h1);
    endtask

    task automatic drive_tick(input logic [DB-1:0] l, input logic [DB-1:0] r);
        tick = 1'b1;
        a0   = l;
        a1   = r;
        @(negedge clk);
        fc++;
        tick = 1'b0;
    endtask

    // Scoreboard monitor: every req starts a frame; 48 bits are captured on
    // sck rising edges and compared against the next queued expectation.
    initial begin : monitor
        logic        prev_sck;
        logic        collecting;
        logic        have_prev;
        logic        brk;
        int          nbits;
        int          cyc;
        int          last_req;
        int          seen_restart;
        logic [47:0] sh;
        prev_sck = 1'b0; collecting = 1'b0; have_prev = 1'b0; brk = 1'b0;
        nbits = 0; cyc = 0; last_req = 0; seen_restart = 0; sh = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                if (collecting && exp_q.size() > 0) void'(exp_q.pop_front());
                collecting = 1'b0;
                brk = 1'b1;
            end else begin
                if (restart_cnt != seen_restart) begin
                    brk = 1'b1;
                    seen_restart = restart_cnt;
                end
                if (req) begin
                    if (have_prev && !brk) check("req_period", 48'(cyc - last_req), 48'(FRAME_CYC));
                    have_prev = 1'b1;
                    brk = 1'b0;
                    last_req = cyc;
                    collecting = 1'b1;
                    nbits = 0;
                    sh = '0;
                end else if (collecting && !prev_sck && sck) begin
                    sh = {sh[46:0], sdo};
                    nbits++;
                    if (nbits == 48) begin
                        collecting = 1'b0;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_err++;
                            $display("FAIL frame_data: got %h with no expected frame queued", sh);
                        end else begin
                            check("frame_data", sh, exp_q.pop_front());
                        end
                    end
                end
            end
            prev_sck = sck;
        end
    end

    initial begin : stimulus
        logic [7:0] pat;
        int         bad;
        rst = 1'b1; play = 1'b0; tick = 1'b0; a0 = '0; a1 = '0; fc = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 48'({req, sck, ws, sdo}), 48'h0);
        rst = 1'b0;
        @(negedge clk);

        // frame A: nothing buffered yet
        exp_q.push_back(48'h0);
        play = 1'b1;
        wait_req("start_req", 10);
        fc = 0;
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            pat[i] = sck;
            @(negedge clk);
            fc++;
        end
        check("sck_pattern", 48'(pat), 48'hCC);
        to_cyc(10);
        exp_q.push_back(48'hA5F00F800001);
        drive_tick(24'hA5F00F, 24'h800001);
        to_cyc(91);  check("ws_bit22", 48'(ws), 48'h0);
        to_cyc(92);  check("ws_bit23", 48'(ws), 48'h1);
        to_cyc(187); check("ws_bit46", 48'(ws), 48'h1);
        to_cyc(188); check("ws_bit47", 48'(ws), 48'h0);

        // frame B carries the tick; no tick during B, so C underruns
        wait_req("frame_b_req", 300);
        fc = 0;
        exp_q.push_back(48'h0);
        wait_req("frame_c_req", 300);
        fc = 0;
        to_cyc(50);
        exp_q.push_back(48'h111111222222);
        drive_tick(24'h111111, 24'h222222);
        to_cyc(191);
        exp_q.push_back(48'h123456654321);
        drive_tick(24'h123456, 24'h654321);
        check("load_tick_req", 48'(req), 48'h1);
        fc = 0;

        // frame E: stop requested at bit 10
        wait_req("frame_e_req", 300);
        fc = 0;
        to_cyc(40);
        play = 1'b0;
        to_cyc(192);
        bad = 0;
        for (int i = 0; i < 520; i++) begin
            if ({req, sck, ws, sdo} != 4'b0) bad++;
            @(negedge clk);
            fc++;
        end
        check("idle_quiet", 48'(bad), 48'h0);

        // restart, then stop/resume within the same frame
        exp_q.push_back(48'h0);
        restart_cnt++;
        play = 1'b1;
        wait_req("restart_req", 10);
        fc = 0;
        to_cyc(20);
        exp_q.push_back(48'hDEADBE0F1E2D);
        drive_tick(24'hDEADBE, 24'h0F1E2D);
        to_cyc(40);
        play = 1'b0;
        to_cyc(160);
        play = 1'b1;
        wait_req("seamless_req", 300);
        check("seamless_req_cycle", 48'(fc), 48'(FRAME_CYC));
        fc = 0;

        // reset mid-frame at bit 30 with play held high
        exp_q.push_back(48'h0);
        to_cyc(120);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs", 48'({req, sck, ws, sdo}), 48'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rerun_req", 48'(req), 48'h1);
        fc = 0;
        to_cyc(10);
        play = 1'b0;
        to_cyc(200);
        check("queue_drained", 48'(exp_q.size()), 48'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/i2s_unit.md
Name: i2s_unit

Overview:
Audio serial transmitter in the mclk domain. It sits on the far side of the clock-domain crossing from the control/DSP logic: it requests sample pairs, accepts them on a tick, and serialises them as I2S (left channel then right, MSB first) with generated serial clock and word select. It drives the req handshake back across the crossing and consumes the crossed play/tick/data signals.

Parameters:
DATABITS, 24, bits per channel sample; frame = 2*DATABITS bits.
SCK_DIV, 4, clk cycles per sck_out period; even, >= 2.

Ports:
clk  input  1  mclk-domain clock.
rst  input  1  synchronous active-high reset.
play_in  input  1  level; 1 = stream audio, 0 = stop at the next frame end.
tick_in  input  1  one-cycle strobe; audio0_in and audio1_in are valid this cycle.
audio0_in  input  DATABITS  left sample, two's complement.
audio1_in  input  DATABITS  right sample, two's complement.
req_out  output  1  one-cycle pulse requesting the next sample pair.
sck_out  output  1  I2S serial bit clock.
ws_out  output  1  I2S word select; 0 = left, 1 = right.
sdo_out  output  1  I2S serial data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE. All counters, the input buffer and the shift register are 0. req_out, sck_out, ws_out and sdo_out are 0. Reset asserted mid-frame aborts the frame immediately and is not completed.
- Input buffer, 2*DATABITS bits:
  - Loaded with {audio0_in, audio1_in} on any cycle where tick_in=1, in all states.
  - Cleared to 0 on each frame load, so an underrun plays silence.
  - If tick_in and a frame load occur in the same cycle, the shift register takes the old buffer and the buffer then holds the new tick data.
- Counters:
  - cnt runs 0..SCK_DIV-1 and wraps.
  - bitidx runs 0..2*DATABITS-1 and increments when cnt wraps.
  - sck_out is registered: 1 when cnt >= SCK_DIV/2, else 0.
  - Data and ws change only at the sck falling edge (cnt=0).
- Serial output:
  - sdo_out is the shift register MSB. The shift register shifts left, filling with 0, at each cnt wrap.
  - Bit b of the frame is driven for the whole sck period b.
- Word select (I2S one-bit offset): ws_out=1 for bitidx 23..46; ws_out=0 for bitidx 47 and 0..22.
- State machine IDLE / RUN / STOPPING:
  - IDLE to RUN when play_in=1. In the cycle RUN is entered: cnt=0, bitidx=0, shift register loaded from the buffer, req_out=1.
  - RUN:
    - At the end of bitidx 47, cnt=SCK_DIV-1, a new frame starts: shift register loaded, buffer cleared, and req_out pulses 1 cycle in the load cycle.
    - play_in=0 goes to STOPPING.
  - STOPPING:
    - Completes the current frame, then enters IDLE with all outputs 0. No req is issued at that boundary.
    - play_in=1 before the frame end returns to RUN, giving seamless continuation with req at the boundary.
  - IDLE: sck_out, ws_out and sdo_out are held 0 and the counters are frozen at 0.
- req_out is never asserted in IDLE and is at most 1 cycle per frame.
- Frame length is 2*DATABITS*SCK_DIV clk cycles (192 at the defaults).
- The first frame after start is the buffer content, normally 0 because no tick has arrived yet.

Decomposition:
- Shared package audioport_pkg holds:
  - constant AUDIO_BITS=24
  - constant I2S_FRAME_BITS=2*AUDIO_BITS
  - typedef enum i2s_state_t {IDLE, RUN, STOPPING}
- One sub-module, i2s_clkgen, holds cnt and bitidx and produces sck_out, ws_out, a shift strobe and a frame-end strobe. i2s_unit holds the FSM, the buffer and the shift register.

Test Plan:
- Reset, then play_in=1 for 1 cycle. Required: req_out=1 in the RUN entry cycle, sdo_out=0 for the whole first frame, sck_out period 4 cycles, ws_out rises at bit 23 (cycle 92 after start).
- After the first req, tick_in with audio0=24'hA5F00F and audio1=24'h800001. Required: the second frame's sdo stream, sampled at sck rising edges, equals 48'hA5F00F800001 MSB first; a second req appears 192 cycles after the first.
- Missing tick (underrun). Required: the next frame is all zeros and req still pulses every 192 cycles.
- tick_in exactly in a frame-load cycle with 24'h123456/24'h654321, while the buffer holds 24'h111111/24'h222222. Required: the current frame serialises the 1111/2222 pair and the following frame serialises 123456/654321.
- play_in drops at bit 10. Required: the frame completes through bit 47, there is no req at the boundary, and then sck_out, ws_out and sdo_out are 0 for 500+ cycles. play_in re-asserted at bit 40 of STOPPING gives a seamless next frame with req.
- rst=1 asserted mid-frame at bit 30. Required: on the next clk edge all outputs are 0 and state is IDLE; with play_in held 1 and rst released, RUN is re-entered on the following cycle with req.
